pixel_scanner: RTL and testbench
================================

PIXEL_SCANNER -- requirements
Module: pixel_scanner

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch widths in clocks.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch widths in lines.
REQ-005 Parameter SYNC_NEG, default 1: 1 means hsync and vsync are active-low.
REQ-006 Port clk, input, 1: the single clock; every register samples on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port enable, input, 1: when 0, the counters freeze at their current values.
REQ-009 Port pixel_x, output, 10: horizontal coordinate of the requested pixel.
REQ-010 Port pixel_y, output, 10: vertical coordinate of the requested pixel.
REQ-011 Port pixel_valid, output, 1: the current coordinate is inside the active area.
REQ-012 Port rgb_r / rgb_g / rgb_b, input, 8 each: shaded colour returned combinationally for the current coordinate.
REQ-013 Port vga_r / vga_g / vga_b, output, 8 each: registered display colour.
REQ-014 Port vga_hs / vga_vs, output, 1 each: registered sync outputs, aligned with the vga colour outputs.
REQ-015 Port vga_de, output, 1: registered data-enable, aligned with the vga colour outputs.
REQ-016 Port frame_start, output, 1: one-clock pulse issued while h_cnt=0 and v_cnt=0 and enable=1.

Function
REQ-017 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults).
REQ-018 h_cnt SHALL wrap to 0 after H_TOTAL-1, and v_cnt SHALL increment on that same wrap.
REQ-019 v_cnt SHALL count 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-020 v_cnt SHALL wrap to 0 when h_cnt wraps while v_cnt = V_TOTAL-1.
REQ-021 The counters SHALL advance only when enable=1; when enable=0 they hold their values.
REQ-022 Each register feeding the aligned outputs (vga_*, vga_hs, vga_vs, vga_de) SHALL load only when enable=1; otherwise it holds.
REQ-023 pixel_valid SHALL be 1 when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE, and 0 otherwise.
REQ-024 pixel_valid, pixel_x and pixel_y SHALL be driven directly from the counter registers, with no logic added after the registers.
REQ-025 pixel_x SHALL equal h_cnt and pixel_y SHALL equal v_cnt while pixel_valid=1.
REQ-026 pixel_x and pixel_y SHALL both be 0 while pixel_valid=0.
REQ-027 The raw horizontal sync SHALL be asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
REQ-028 The raw vertical sync SHALL be asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
REQ-029 The polarity of both sync outputs SHALL be set by SYNC_NEG.
REQ-030 Output latency SHALL be 1 clock: vga_de, vga_hs and vga_vs SHALL be the cycle-N pixel_valid and raw syncs, registered at edge N+1.
REQ-031 vga_r / vga_g / vga_b SHALL be the cycle-N rgb inputs, registered at edge N+1, when pixel_valid was 1 at cycle N.
REQ-032 vga_r / vga_g / vga_b SHALL be forced to 0 when pixel_valid was 0 at cycle N.
REQ-033 The rgb inputs SHALL be ignored while pixel_valid=0, including any non-zero value.

Reset
REQ-034 On rst=1 at a clock edge, h_cnt SHALL become 0 and v_cnt SHALL become 0, regardless of enable and of any in-progress frame.
REQ-035 On rst=1 at a clock edge, vga_r, vga_g, vga_b and vga_de SHALL become 0.
REQ-036 On rst=1 at a clock edge, vga_hs and vga_vs SHALL take their inactive level (1 when SYNC_NEG=1).
REQ-037 In the first cycle after reset release, pixel_valid SHALL be 1 with pixel_x=0 and pixel_y=0.
REQ-038 In the first cycle after reset release, frame_start SHALL be 1 if enable=1.

Structure
REQ-039 A shared package pixel_timing_pkg SHALL hold the default timing constants, the derived H_TOTAL / V_TOTAL, and the 10-bit coordinate typedef.
REQ-040 One sub-module, sync_counter, SHALL implement a single axis (count, wrap, active flag, sync window) and SHALL be instantiated once for each axis.
REQ-041 The horizontal wrap output of sync_counter SHALL drive the advance input of the vertical instance.

Verification
REQ-042 Reset held 3 clocks, then released with enable=1 -> the first cycle shows pixel_valid=1, pixel_x=0, pixel_y=0, frame_start=1, and vga_hs=vga_vs=1 on the following edge.
REQ-043 Run one line -> pixel_valid is high for 640 consecutive clocks; vga_hs is low for exactly 96 clocks, starting 657 clocks after the line start; the line period is 800 clocks.
REQ-044 Run a full frame -> frame_start pulses exactly 420000 clocks apart; vga_vs is low for exactly 1600 clocks, starting at line 490.
REQ-045 Drive rgb=(0x12,0x34,0x56) at pixel (639,479), then rgb=(0xFF,0xFF,0xFF) at h_cnt=640 -> the vga colour is 0x123456 one clock later, then 0x000000 (blanked).
REQ-046 Hold enable=0 for 50 clocks in mid-line at pixel_x=100 -> pixel_x stays 100 and the vga outputs hold; after enable returns to 1, counting resumes at 101.
REQ-047 Assert rst for 1 clock at v_cnt=300, h_cnt=400 -> the next cycle shows pixel (0,0) and vga_de=0, and the frame restarts cleanly.

Source files
------------

// File: rtl/pixel_timing_pkg.sv
// Shared display timing constants, coordinate type and colour/output bundles
// used by the pixel scanner and its per-axis counter.
package pixel_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t rgb;
    logic hs;
    logic vs;
    logic de;
  } vga_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/pixel_scanner_if.sv
// Pixel request/shade bus and registered display outputs of the scanner.
interface pixel_scanner_if;
  import pixel_timing_pkg::*;

  coord_t     pixel_x;
  coord_t     pixel_y;
  logic       pixel_valid;
  logic       frame_start;
  logic [7:0] rgb_r;
  logic [7:0] rgb_g;
  logic [7:0] rgb_b;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_de;

  modport master (
    output pixel_x, pixel_y, pixel_valid, frame_start,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
    input  rgb_r, rgb_g, rgb_b
  );

  modport slave (
    input  pixel_x, pixel_y, pixel_valid, frame_start,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
    output rgb_r, rgb_g, rgb_b
  );

endinterface

// File: rtl/sync_counter.sv
// One display axis: position counter with wrap, plus active-area and
// sync-window decode. The next count is exported so the caller can register
// derived outputs in step with the counter.
module sync_counter
  import pixel_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   advance_i,
  output coord_t cnt_o,
  output coord_t cnt_next_o,
  output logic   wrap_o,
  output logic   active_next_o,
  output logic   sync_o
);

  localparam coord_t LAST       = coord_t'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam coord_t ACT_END    = coord_t'(ACTIVE);
  localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

  coord_t cnt_q;
  coord_t cnt_d;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (advance_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + coord_t'(1);
    end
  end

  // NOTE: flops take non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign cnt_next_o    = cnt_d;
  assign wrap_o        = advance_i && (cnt_q == LAST);
  assign active_next_o = (cnt_d < ACT_END);
  assign sync_o        = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

endmodule

// File: rtl/pixel_scanner.sv
// Raster scanner: walks the screen, requests shaded pixels for the active
// area and emits colour, syncs and data-enable one clock later.
module pixel_scanner
  import pixel_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  pixel_scanner_if.master scan
);

  coord_t h_cnt, h_next, v_cnt, v_next;
  logic   h_wrap, v_wrap_unused;
  logic   h_act_next, v_act_next;
  logic   h_sync_raw, v_sync_raw;

  sync_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk           (clk),
    .rst           (rst),
    .advance_i     (enable),
    .cnt_o         (h_cnt),
    .cnt_next_o    (h_next),
    .wrap_o        (h_wrap),
    .active_next_o (h_act_next),
    .sync_o        (h_sync_raw)
  );

  sync_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk           (clk),
    .rst           (rst),
    .advance_i     (h_wrap),
    .cnt_o         (v_cnt),
    .cnt_next_o    (v_next),
    .wrap_o        (v_wrap_unused),
    .active_next_o (v_act_next),
    .sync_o        (v_sync_raw)
  );

  // Coordinates are registered from the next counts so the port bits come
  // straight off flops while still reading zero outside the active area.
  logic   valid_d, valid_q;
  coord_t x_d, x_q, y_d, y_q;

  always_comb begin
    valid_d = h_act_next && v_act_next;
    x_d     = valid_d ? h_next : '0;
    y_d     = valid_d ? v_next : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  vga_t vga_d, vga_q;

  always_comb begin
    vga_d.rgb = valid_q ? rgb_t'({scan.rgb_r, scan.rgb_g, scan.rgb_b}) : rgb_t'('0);
    vga_d.hs  = h_sync_raw ^ SYNC_NEG;
    vga_d.vs  = v_sync_raw ^ SYNC_NEG;
    vga_d.de  = valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_q.rgb <= '0;
      vga_q.hs  <= SYNC_NEG;
      vga_q.vs  <= SYNC_NEG;
      vga_q.de  <= 1'b0;
    end else if (enable) begin
      vga_q <= vga_d;
    end
  end

  assign scan.pixel_x     = x_q;
  assign scan.pixel_y     = y_q;
  assign scan.pixel_valid = valid_q;
  assign scan.frame_start = (h_cnt == '0) && (v_cnt == '0) && enable;
  assign scan.vga_r       = vga_q.rgb.r;
  assign scan.vga_g       = vga_q.rgb.g;
  assign scan.vga_b       = vga_q.rgb.b;
  assign scan.vga_hs      = vga_q.hs;
  assign scan.vga_vs      = vga_q.vs;
  assign scan.vga_de      = vga_q.de;

endmodule

// File: tb/tb_pixel_scanner.sv
// Bench for pixel_scanner: a default-timing instance and a shrunken-timing
// instance run side by side against a position-based reference model.
module tb_pixel_scanner;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
  } tm_t;

  localparam tm_t TS = '{ha: 40, hf: 4, hs: 8, hb: 6, va: 30, vf: 3, vs: 2, vb: 4};
  localparam tm_t TD = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] rgb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_scanner_if s_if ();
  pixel_scanner_if d_if ();

  assign s_if.rgb_r = rgb[23:16];
  assign s_if.rgb_g = rgb[15:8];
  assign s_if.rgb_b = rgb[7:0];
  assign d_if.rgb_r = rgb[23:16];
  assign d_if.rgb_g = rgb[15:8];
  assign d_if.rgb_b = rgb[7:0];

  pixel_scanner #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(4), .SYNC_NEG(1'b1)
  ) u_small (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .scan   (s_if)
  );

  pixel_scanner u_dflt (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .scan   (d_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pixel-side outputs for the t-th enabled cycle since reset: {x, y, valid, frame_start}.
  function automatic logic [21:0] pix_exp(input tm_t p, input int t, input logic en);
    int   ht = p.ha + p.hf + p.hs + p.hb;
    int   vt = p.va + p.vf + p.vs + p.vb;
    int   h  = t % ht;
    int   v  = (t / ht) % vt;
    logic val = (h < p.ha) && (v < p.va);
    return {val ? 10'(h) : 10'd0, val ? 10'(v) : 10'd0, val, (h == 0) && (v == 0) && en};
  endfunction

  // Display outputs captured from the t-th position: {r, g, b, hs, vs, de}, active-low syncs.
  function automatic logic [26:0] vga_exp(input tm_t p, input int t, input logic [23:0] c);
    int   ht = p.ha + p.hf + p.hs + p.hb;
    int   vt = p.va + p.vf + p.vs + p.vb;
    int   h  = t % ht;
    int   v  = (t / ht) % vt;
    logic val = (h < p.ha) && (v < p.va);
    logic hs = !((h >= p.ha + p.hf) && (h < p.ha + p.hf + p.hs));
    logic vs = !((v >= p.va + p.vf) && (v < p.va + p.vf + p.vs));
    return {val ? c : 24'h0, hs, vs, val};
  endfunction

  int          t_s, t_d;
  logic [26:0] vga_s, vga_d;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      t_s      <= 0;
      t_d      <= 0;
      vga_s    <= {24'h0, 1'b1, 1'b1, 1'b0};
      vga_d    <= {24'h0, 1'b1, 1'b1, 1'b0};
      model_on <= 1'b1;
    end else if (model_on && enable) begin
      vga_s <= vga_exp(TS, t_s, rgb);
      vga_d <= vga_exp(TD, t_d, rgb);
      t_s   <= t_s + 1;
      t_d   <= t_d + 1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_pix_small", {10'h0, s_if.pixel_x, s_if.pixel_y, s_if.pixel_valid, s_if.frame_start},
            {10'h0, pix_exp(TS, t_s, enable)});
      check("model_vga_small", {5'h0, s_if.vga_r, s_if.vga_g, s_if.vga_b, s_if.vga_hs, s_if.vga_vs, s_if.vga_de},
            {5'h0, vga_s});
      check("model_pix_dflt", {10'h0, d_if.pixel_x, d_if.pixel_y, d_if.pixel_valid, d_if.frame_start},
            {10'h0, pix_exp(TD, t_d, enable)});
      check("model_vga_dflt", {5'h0, d_if.vga_r, d_if.vga_g, d_if.vga_b, d_if.vga_hs, d_if.vga_vs, d_if.vga_de},
            {5'h0, vga_d});
    end
  end

  // Inputs change 2 time units after the edge; directed samples are taken 2 units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Step until the chosen instance shows (x, y); y < 0 matches any line.
  task automatic seek(input bit dflt, input int x, input int y, output bit found);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      #2;
      if (dflt) found = (int'(d_if.pixel_x) == x) && d_if.pixel_valid && (y < 0 || int'(d_if.pixel_y) == y);
      else      found = (int'(s_if.pixel_x) == x) && s_if.pixel_valid && (y < 0 || int'(s_if.pixel_y) == y);
    end
  endtask

  // From a small-instance frame_start cycle, count cycles to the next one and track vsync.
  task automatic measure_frame(output int period, output int vs_first, output int vs_low);
    bit seen = 1'b0;
    period   = -1;
    vs_first = -1;
    vs_low   = 0;
    for (int k = 1; k <= 3000 && !seen; k++) begin
      tick();
      #2;
      if (s_if.frame_start) begin
        seen   = 1'b1;
        period = k;
      end else if (!s_if.vga_vs) begin
        if (vs_first < 0) vs_first = k;
        vs_low++;
      end
    end
  endtask

  initial begin
    int valid_cnt, hs_first, hs_low, period, vs_first, vs_low;
    bit found;

    rst    = 1'b1;
    enable = 1'b1;
    rgb    = 24'h0;
    repeat (3) tick();
    rst = 1'b0;
    #2;
    check("rst_valid", 32'(d_if.pixel_valid), 32'd1);
    check("rst_x", 32'(d_if.pixel_x), 32'd0);
    check("rst_y", 32'(d_if.pixel_y), 32'd0);
    check("rst_frame_start", 32'(d_if.frame_start), 32'd1);

    valid_cnt = int'(d_if.pixel_valid);
    hs_first  = -1;
    hs_low    = 0;
    for (int k = 1; k <= 800; k++) begin
      tick();
      rgb = {8'(k), 8'(k * 3), 8'(255 - k)};
      #2;
      if (k == 1) begin
        check("first_hs", 32'(d_if.vga_hs), 32'd1);
        check("first_vs", 32'(d_if.vga_vs), 32'd1);
        check("first_de", 32'(d_if.vga_de), 32'd1);
      end
      if (k < 800) begin
        valid_cnt += int'(d_if.pixel_valid);
        if (!d_if.vga_hs) begin
          if (hs_first < 0) hs_first = k;
          hs_low++;
        end
      end else begin
        check("line2_x", 32'(d_if.pixel_x), 32'd0);
        check("line2_y", 32'(d_if.pixel_y), 32'd1);
        check("line2_valid", 32'(d_if.pixel_valid), 32'd1);
      end
    end
    check("line_valid_count", 32'(valid_cnt), 32'd640);
    check("hs_first_low", 32'(hs_first), 32'd657);
    check("hs_low_count", 32'(hs_low), 32'd96);

    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      #2;
      found = s_if.frame_start;
    end
    check("frame_start_seen", 32'(found), 32'd1);
    measure_frame(period, vs_first, vs_low);
    check("frame_period", 32'(period), 32'd2262);
    check("vs_first_low", 32'(vs_first), 32'd1915);
    check("vs_low_count", 32'(vs_low), 32'd116);

    seek(1'b0, 39, 29, found);
    check("seek_last_pixel", 32'(found), 32'd1);
    rgb = 24'h123456;
    tick();
    rgb = 24'hFFFFFF;
    #2;
    check("last_pixel_colour", {8'h0, s_if.vga_r, s_if.vga_g, s_if.vga_b}, 32'h0012_3456);
    tick();
    #2;
    check("blank_colour", {8'h0, s_if.vga_r, s_if.vga_g, s_if.vga_b}, 32'h0);
    rgb = 24'hA5C33C;

    seek(1'b1, 100, -1, found);
    check("seek_x100", 32'(found), 32'd1);
    enable = 1'b0;
    repeat (50) tick();
    #2;
    check("hold_x", 32'(d_if.pixel_x), 32'd100);
    check("hold_de", 32'(d_if.vga_de), 32'd1);
    enable = 1'b1;
    tick();
    #2;
    check("resume_x", 32'(d_if.pixel_x), 32'd101);

    seek(1'b0, 30, 20, found);
    check("seek_mid_frame", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("mid_rst_x", 32'(s_if.pixel_x), 32'd0);
    check("mid_rst_y", 32'(s_if.pixel_y), 32'd0);
    check("mid_rst_valid", 32'(s_if.pixel_valid), 32'd1);
    check("mid_rst_de", 32'(s_if.vga_de), 32'd0);
    check("mid_rst_frame_start", 32'(s_if.frame_start), 32'd1);
    measure_frame(period, vs_first, vs_low);
    check("restart_period", 32'(period), 32'd2262);
    check("restart_vs_low", 32'(vs_low), 32'd116);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
